// File: rtl/rs_stream_encoder.sv
// Systematic RS(N, N-2) encoder over GF(2^SYMBOL_WIDTH): serial message in, packed codeword out.
// A two-stage LFSR divides by g(x) = (x+a)(x+a^2); message plus parity leave on a parallel bus.
`timescale 1ns/1ps

module rs_stream_gf_mul #(
    parameter int                    SYMBOL_WIDTH = 3,
    parameter logic [SYMBOL_WIDTH:0] PRIM_POLY    = 4'b1011
) (
    input  logic [SYMBOL_WIDTH-1:0] a,
    input  logic [SYMBOL_WIDTH-1:0] b,
    output logic [SYMBOL_WIDTH-1:0] p
);
    logic [SYMBOL_WIDTH-1:0] acc;
    logic [SYMBOL_WIDTH-1:0] shifted;

    // Shift-and-add: 'shifted' walks through a, a*x, a*x^2, ... reduced mod PRIM_POLY.
    always_comb begin
        acc     = '0;
        shifted = a;
        for (int i = 0; i < SYMBOL_WIDTH; i++) begin
            if (b[i]) begin
                acc = acc ^ shifted;
            end
            if (shifted[SYMBOL_WIDTH-1]) begin
                shifted = (shifted << 1) ^ PRIM_POLY[SYMBOL_WIDTH-1:0];
            end else begin
                shifted = shifted << 1;
            end
        end
        p = acc;
    end
endmodule

module rs_stream_encoder #(
    parameter int                      N            = 7,
    parameter int                      SYMBOL_WIDTH = 3,
    parameter logic [SYMBOL_WIDTH:0]   PRIM_POLY    = 4'b1011,
    parameter logic [SYMBOL_WIDTH-1:0] G1           = 3'd6,
    parameter logic [SYMBOL_WIDTH-1:0] G0           = 3'd3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SYMBOL_WIDTH-1:0]   in_symbol,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N*SYMBOL_WIDTH-1:0] codeword
);
    localparam int K      = N - 2;
    localparam int CNT_W  = $clog2(N);

    // Handshakes: a transfer happens on a rising clk edge where valid && ready.
    // in_ready/out_valid depend on state only, so ACCEPT and HOLD never overlap.
    typedef enum logic {
        ACCEPT = 1'b0,
        HOLD   = 1'b1
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [CNT_W-1:0]          count;
    logic [SYMBOL_WIDTH-1:0]   r1;
    logic [SYMBOL_WIDTH-1:0]   r0;
    logic [N*SYMBOL_WIDTH-1:0] cw_q;
    logic [N*SYMBOL_WIDTH-1:0] cw_next;

    logic [SYMBOL_WIDTH-1:0]   fb;
    logic [SYMBOL_WIDTH-1:0]   fb_g1;
    logic [SYMBOL_WIDTH-1:0]   fb_g0;
    logic [SYMBOL_WIDTH-1:0]   r1_next;
    logic [SYMBOL_WIDTH-1:0]   r0_next;
    logic                      in_accept;
    logic                      out_accept;
    logic                      last_sym;

    assign fb = in_symbol ^ r1;

    rs_stream_gf_mul #(
        .SYMBOL_WIDTH(SYMBOL_WIDTH),
        .PRIM_POLY   (PRIM_POLY)
    ) u_mul_g1 (
        .a(fb),
        .b(G1),
        .p(fb_g1)
    );

    rs_stream_gf_mul #(
        .SYMBOL_WIDTH(SYMBOL_WIDTH),
        .PRIM_POLY   (PRIM_POLY)
    ) u_mul_g0 (
        .a(fb),
        .b(G0),
        .p(fb_g0)
    );

    assign r1_next    = r0 ^ fb_g1;
    assign r0_next    = fb_g0;
    assign in_accept  = in_valid && in_ready;
    assign out_accept = out_valid && out_ready;
    assign last_sym   = (count == CNT_W'(K - 1));
    assign codeword   = cw_q;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid && last_sym) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ACCEPT;
                end
            end
            default: state_next = ACCEPT;
        endcase
    end

    // Message symbols land first-in at the top slot; the final accept also drops in the parity.
    always_comb begin
        cw_next = cw_q;
        for (int i = 2; i < N; i++) begin
            if (count == CNT_W'(N - 1 - i)) begin
                cw_next[i*SYMBOL_WIDTH +: SYMBOL_WIDTH] = in_symbol;
            end
        end
        if (last_sym) begin
            cw_next[SYMBOL_WIDTH +: SYMBOL_WIDTH] = r1_next;
            cw_next[0 +: SYMBOL_WIDTH]            = r0_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACCEPT;
            count <= '0;
            r1    <= '0;
            r0    <= '0;
            cw_q  <= '0;
        end else begin
            state <= state_next;
            if (in_accept) begin
                r1    <= r1_next;
                r0    <= r0_next;
                count <= count + CNT_W'(1);
                cw_q  <= cw_next;
            end else if (out_accept) begin
                // Codeword register keeps its value; only the encoder core is rearmed.
                r1    <= '0;
                r0    <= '0;
                count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_rs_stream_encoder.sv
// Self-checking bench for rs_stream_encoder: scoreboard of expected codewords, parity
// model found by brute-force search for the pair that zeroes both syndromes.
`timescale 1ns/1ps

module tb_rs_stream_encoder;
  localparam int N   = 7;
  localparam int SW  = 3;
  localparam int K   = N - 2;
  localparam int CWW = N * SW;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [SW-1:0]  in_symbol;
  logic           out_valid;
  logic           out_ready;
  logic [CWW-1:0] codeword;

  logic [CWW-1:0] exp_q[$];
  int             n_checks = 0;
  int             n_errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  rs_stream_encoder #(.N(N), .SYMBOL_WIDTH(SW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_symbol(in_symbol),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .codeword (codeword)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  function automatic logic [SW-1:0] gf_mul(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [2*SW-2:0] prod = '0;
    for (int i = 0; i < SW; i++) if (b[i]) prod ^= (2*SW-1)'(a) << i;
    for (int i = 2*SW-2; i >= SW; i--) if (prod[i]) prod ^= (2*SW-1)'(4'b1011) << (i - SW);
    return prod[SW-1:0];
  endfunction

  function automatic logic [SW-1:0] syndrome(input logic [CWW-1:0] cw, input logic [SW-1:0] beta);
    logic [SW-1:0] s = '0;
    for (int i = N - 1; i >= 0; i--) s = gf_mul(s, beta) ^ cw[i*SW +: SW];
    return s;
  endfunction

  function automatic logic [CWW-1:0] model_cw(input logic [K*SW-1:0] msg);
    logic [CWW-1:0] cw;
    for (int p1 = 0; p1 < (1 << SW); p1++) begin
      for (int p0 = 0; p0 < (1 << SW); p0++) begin
        cw = {msg, SW'(p1), SW'(p0)};
        if (syndrome(cw, 3'd2) == 0 && syndrome(cw, 3'd4) == 0) return cw;
      end
    end
    return '0;
  endfunction

  // scoreboard: pop on every output transfer
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      check("codeword_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("codeword", 64'(codeword), 64'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input logic [SW-1:0] sym, input int max_gap);
    bit acc = 1'b0;
    int gaps = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    repeat (gaps) begin
      in_valid  = 1'b0;
      in_symbol = SW'($urandom);
      tick();
    end
    in_valid  = 1'b1;
    in_symbol = sym;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    check("in_ready_wait", 64'(acc), 64'd1);
  endtask

  task automatic send_msg(input logic [K*SW-1:0] msg, input int max_gap, input logic [CWW-1:0] exp_cw);
    for (int j = 0; j < K; j++) begin
      if (j == K - 1) exp_q.push_back(exp_cw);
      send_sym(msg[(K-1-j)*SW +: SW], max_gap);
    end
    in_valid = 1'b0;
    check("out_valid_latency", 64'(out_valid), 64'd1);
    check("in_ready_in_hold", 64'(in_ready), 64'd0);
  endtask

  task automatic drain(input bit random_ready);
    int t = 0;
    while (!in_ready && t < 200) begin
      out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      t++;
    end
    out_ready = 1'b1;
    check("drain_done", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [K*SW-1:0] msg;
    logic [CWW-1:0]  exp_cw;

    reset = 1'b1; in_valid = 1'b0; in_symbol = '0; out_ready = 1'b1;
    #3;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_codeword", 64'(codeword), 64'd0);
    #9 reset = 1'b0;
    tick();

    // all-zero message, back-to-back
    send_msg('0, 0, '0);
    tick();
    check("in_ready_after_out", 64'(in_ready), 64'd1);
    check("out_valid_after_out", 64'(out_valid), 64'd0);

    send_msg(15'o00001, 0, 21'o0000163);
    drain(1'b0);
    send_msg(15'o10000, 0, 21'o1000062);
    drain(1'b0);
    send_msg(15'o10000, 3, 21'o1000062);
    drain(1'b0);

    // backpressure with in_valid held high
    out_ready = 1'b0;
    msg = 15'o34567;
    exp_cw = model_cw(msg);
    send_msg(msg, 0, exp_cw);
    in_valid  = 1'b1;
    in_symbol = 3'd5;
    repeat (10) begin
      @(negedge clk);
      check("bp_codeword", 64'(codeword), 64'(exp_cw));
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_release", 64'(in_ready), 64'd1);
    msg = 15'o12345;
    send_msg(msg, 0, model_cw(msg));
    drain(1'b0);

    // random messages, gaps and random downstream stalls
    for (int r = 0; r < 6; r++) begin
      msg = (K*SW)'($urandom);
      send_msg(msg, 2, model_cw(msg));
      drain(1'b1);
    end

    // asynchronous reset mid-message
    send_sym(3'd7, 0);
    send_sym(3'd2, 0);
    send_sym(3'd6, 0);
    in_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_in_ready", 64'(in_ready), 64'd1);
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_codeword", 64'(codeword), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    send_msg(15'o00001, 0, 21'o0000163);
    drain(1'b0);

    repeat (3) tick();
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
